// File: rtl/axi2s_pkg.sv
// Shared types and constants for the sample-to-AXI path.
package axi2s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StStop
  } state_e;

  localparam int unsigned SAMPLE_W        = 12;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned FRAME_WORDS_DEF = 16;

  function automatic logic [WORD_W/2-1:0] sext(input logic [SAMPLE_W-1:0] x);
    return {{(WORD_W/2 - SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

endpackage

// File: rtl/iq_pack_stage.sv
// Sign-extends an I/Q pair, orders the halves and registers the packed word.
module iq_pack_stage
  import axi2s_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SAMPLE_W-1:0] i_smp_i,
  input  logic [SAMPLE_W-1:0] q_smp_i,
  input  logic                swap_i,
  input  logic                load_i,
  output logic [WORD_W-1:0]   word_o,
  output logic                vld_o
);

  logic [WORD_W-1:0] word_d, word_q;
  logic              vld_q;

  always_comb begin
    word_d = swap_i ? {sext(i_smp_i), sext(q_smp_i)} : {sext(q_smp_i), sext(i_smp_i)};
  end

  // Word holds its last value between loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= load_i;
      if (load_i) word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/iq_sample_packer.sv
// Decimates and packs I/Q pairs into 32-bit words; capture starts and stops on frame boundaries.
module iq_sample_packer
  import axi2s_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                Sclk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] adc_i,
  input  logic [SAMPLE_W-1:0] adc_q,
  input  logic                adc_vld,
  input  logic                start,
  input  logic [3:0]          decim,
  input  logic                swap_iq,
  output logic [WORD_W-1:0]   Sin,
  output logic                Ien,
  output logic                sync,
  output logic                busy,
  output logic [CNT_W-1:0]    word_cnt
);

  localparam int unsigned PosW = $clog2(FRAME_WORDS);

  state_e           state_q;
  logic [3:0]       decim_q, dcnt_q;
  logic             swap_q, sync_q;
  logic [PosW-1:0]  pos_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             active, keep, last;

  always_comb begin
    active = (state_q != StIdle);
    keep   = active && adc_vld && (dcnt_q == 4'd0);
    last   = (pos_q == PosW'(FRAME_WORDS - 1));
  end

  always_ff @(posedge Sclk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      decim_q    <= '0;
      dcnt_q     <= '0;
      swap_q     <= 1'b0;
      sync_q     <= 1'b0;
      pos_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      sync_q <= keep && (pos_q == '0);
      if (active && adc_vld) dcnt_q <= (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;
      if (keep) begin
        pos_q      <= pos_q + 1'b1;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StArm;
            decim_q    <= decim;
            swap_q     <= swap_iq;
            dcnt_q     <= '0;
            pos_q      <= '0;
            word_cnt_q <= '0;
          end
        end
        // A pair kept on the cycle start falls is still emitted; finish its frame in StStop.
        StArm: begin
          if (!start) state_q <= keep ? StStop : StIdle;
          else if (keep) state_q <= StRun;
        end
        StRun: begin
          if (!start) begin
            if (keep) state_q <= last ? StIdle : StStop;
            else state_q <= (pos_q == '0) ? StIdle : StStop;
          end
        end
        StStop: begin
          if (keep && last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  iq_pack_stage u_pack (
    .clk_i   (Sclk),
    .rst_ni  (rst),
    .i_smp_i (adc_i),
    .q_smp_i (adc_q),
    .swap_i  (swap_q),
    .load_i  (keep),
    .word_o  (Sin),
    .vld_o   (Ien)
  );

  assign sync     = sync_q;
  assign busy     = (state_q != StIdle);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Scoreboard bench for iq_sample_packer: a reference model queues expected words per cycle.
module tb_iq_sample_packer;

  localparam int unsigned FW = 16;

  logic        Sclk, rst;
  logic [11:0] adc_i, adc_q;
  logic        adc_vld, start, swap_iq;
  logic [3:0]  decim;
  logic [31:0] Sin, word_cnt;
  logic        Ien, sync, busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int unsigned m_st, m_pos, m_dc, m_decim;
  logic        m_swap;
  logic [31:0] m_words;
  logic [31:0] exp_sin;
  logic [32:0] sb[$];
  bit          rnd;

  iq_sample_packer #(
    .FRAME_WORDS (FW),
    .CNT_W       (32)
  ) dut (
    .Sclk     (Sclk),
    .rst      (rst),
    .adc_i    (adc_i),
    .adc_q    (adc_q),
    .adc_vld  (adc_vld),
    .start    (start),
    .decim    (decim),
    .swap_iq  (swap_iq),
    .Sin      (Sin),
    .Ien      (Ien),
    .sync     (sync),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [11:0] i, input logic [11:0] q,
                                       input logic sw);
    logic [15:0] si, sq;
    si = 16'($signed(i));
    sq = 16'($signed(q));
    return sw ? {si, sq} : {sq, si};
  endfunction

  // One clock: model step at the edge, compare #1 later, return at the falling edge.
  task automatic tick();
    logic [32:0] e;
    logic        exp_ien, exp_sync;
    bit          kp;
    if (rnd) {adc_i, adc_q} = 24'($urandom);
    @(posedge Sclk);
    if (!rst) begin
      m_st = 0; m_pos = 0; m_dc = 0; m_words = '0; exp_sin = '0;
      sb.delete();
    end else begin
      kp = (m_st != 0) && adc_vld && (m_dc == 0);
      if (m_st != 0 && adc_vld) m_dc = (m_dc == m_decim) ? 0 : m_dc + 1;
      if (kp) begin
        sb.push_back({m_pos == 0, pack(adc_i, adc_q, m_swap)});
        m_pos = (m_pos + 1) % FW;
        m_words = m_words + 1;
      end
      case (m_st)
        0: if (start) begin
          m_st = 1; m_decim = decim; m_swap = swap_iq; m_dc = 0; m_pos = 0; m_words = '0;
        end
        1, 2: if (!start) m_st = (m_pos == 0) ? 0 : 3;
              else if (kp) m_st = 2;
        3: if (kp && m_pos == 0) m_st = 0;
        default: m_st = 0;
      endcase
    end
    #1;
    exp_ien  = (sb.size() > 0);
    exp_sync = 1'b0;
    check_eq("ien", 64'(Ien), 64'(exp_ien));
    if (exp_ien) begin
      e = sb.pop_front();
      exp_sin  = e[31:0];
      exp_sync = e[32];
    end
    check_eq("sin", 64'(Sin), 64'(exp_sin));
    check_eq("sync", 64'(sync), 64'(exp_sync));
    check_eq("busy", 64'(busy), 64'(m_st != 0));
    check_eq("word_cnt", 64'(word_cnt), 64'(m_words));
    @(negedge Sclk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      if (!busy) break;
      tick();
    end
    check_eq("drain_idle", 64'(busy), 64'(0));
  endtask

  int n_ien;

  initial begin
    rst = 1'b0; start = 1'b0; adc_vld = 1'b0; decim = '0; swap_iq = 1'b0;
    adc_i = '0; adc_q = '0; rnd = 1'b0;
    m_st = 0; m_pos = 0; m_dc = 0; m_decim = 0; m_swap = 1'b0; m_words = '0; exp_sin = '0;
    @(negedge Sclk);
    run(2);
    check_eq("rst_sin", 64'(Sin), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    run(2);

    // 1: every pair kept, first word two cycles after start
    start = 1'b1; decim = 4'd0; adc_vld = 1'b1; adc_i = 12'h800; adc_q = 12'h7FF;
    tick();
    check_eq("t1_lat_ien0", 64'(Ien), 64'(0));
    tick();
    check_eq("t1_lat_ien1", 64'(Ien), 64'(1));
    check_eq("t1_word", 64'(Sin), 64'(32'h07FF_F800));
    check_eq("t1_sync0", 64'(sync), 64'(1));
    run(40);
    start = 1'b0;
    wait_idle(40);
    adc_vld = 1'b0;
    run(3);

    // 2: decim=3, one word per four cycles
    rnd = 1'b1; decim = 4'd3; start = 1'b1; adc_vld = 1'b1;
    run(65);
    check_eq("t2_cnt16", 64'(word_cnt), 64'(16));
    start = 1'b0;
    wait_idle(100);
    adc_vld = 1'b0;
    run(3);

    // 3: start dropped on frame word 5
    decim = 4'd0; start = 1'b1; adc_vld = 1'b1;
    run(6);
    start = 1'b0;
    tick();
    check_eq("t3_word5_sync", 64'(sync), 64'(0));
    n_ien = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Ien) n_ien++;
    end
    check_eq("t3_tail_words", 64'(n_ien), 64'(10));
    check_eq("t3_busy", 64'(busy), 64'(0));
    adc_vld = 1'b0;

    // 4: start pulse in ARM with no valid pairs
    start = 1'b1;
    run(3);
    start = 1'b0;
    run(3);
    check_eq("t4_busy", 64'(busy), 64'(0));
    check_eq("t4_cnt", 64'(word_cnt), 64'(0));

    // 5: reset mid-frame, then restart
    start = 1'b1; adc_vld = 1'b1;
    run(8);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_sin", 64'(Sin), 64'(0));
    check_eq("t5_rst_ien", 64'(Ien), 64'(0));
    check_eq("t5_rst_busy", 64'(busy), 64'(0));
    check_eq("t5_rst_cnt", 64'(word_cnt), 64'(0));
    start = 1'b0;
    run(2);
    rst = 1'b1;
    run(1);
    start = 1'b1;
    run(2);
    check_eq("t5_restart_sync", 64'(sync), 64'(1));
    check_eq("t5_restart_cnt", 64'(word_cnt), 64'(1));
    run(5);
    start = 1'b0;
    wait_idle(40);
    adc_vld = 1'b0;
    run(2);

    // 6: swap, then a swap_iq change mid-run must not take effect
    rnd = 1'b0; swap_iq = 1'b1; adc_i = 12'h123; adc_q = 12'hFED; start = 1'b1; adc_vld = 1'b1;
    run(2);
    check_eq("t6_swap", 64'(Sin), 64'(32'h0123_FFED));
    swap_iq = 1'b0;
    run(3);
    check_eq("t6_swap_held", 64'(Sin), 64'(32'h0123_FFED));
    start = 1'b0;
    wait_idle(40);
    adc_vld = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
